// File: rtl/pipelined_segment_adder.sv
// Pipelined add/subtract, SEG bits per stage.
// Each stage adds one segment with the carry registered by the previous
// stage. The operand bits that have not been added yet travel with the beat,
// and so do the result segments that are already finished, so a beat always
// sits whole in exactly one stage. All stages advance together on a single
// enable derived from the output handshake.
module pipelined_segment_adder #(
    parameter int WIDTH = 64,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_z,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int NSTG = WIDTH / SEG;

    if ((WIDTH % SEG) != 0) begin : g_bad_cfg
        $error("pipelined_segment_adder: WIDTH must be a multiple of SEG");
    end

    // The whole pipeline moves when the output slot is empty or is being drained.
    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Subtraction is A + ~B + 1. The +1 enters as the carry into stage 0.
    logic [WIDTH-1:0] in_bp;
    assign in_bp = in_sub ? ~in_b : in_b;

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        localparam int ZW = (k + 1) * SEG;     // result bits finished after this stage
        localparam int RW = WIDTH - ZW;        // operand bits still to be added

        logic           v_q, c_q, am_q, bm_q;
        logic [ZW-1:0]  z_q;

        logic           v_d, c_in, am_d, bm_d;
        logic [SEG-1:0] seg_a, seg_b;
        logic [SEG:0]   sum;
        logic [ZW-1:0]  z_d;

        if (k == 0) begin : g_src
            assign v_d   = in_valid;
            assign c_in  = in_sub;
            assign am_d  = in_a[WIDTH-1];
            assign bm_d  = in_bp[WIDTH-1];
            assign seg_a = in_a[SEG-1:0];
            assign seg_b = in_bp[SEG-1:0];
            assign z_d   = sum[SEG-1:0];
        end else begin : g_src
            assign v_d   = g_stg[k-1].v_q;
            assign c_in  = g_stg[k-1].c_q;
            assign am_d  = g_stg[k-1].am_q;
            assign bm_d  = g_stg[k-1].bm_q;
            assign seg_a = g_stg[k-1].g_skew.a_q[SEG-1:0];
            assign seg_b = g_stg[k-1].g_skew.b_q[SEG-1:0];
            assign z_d   = {sum[SEG-1:0], g_stg[k-1].z_q};
        end

        assign sum = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG{1'b0}}, c_in};

        // Stage result: valid bit, carry, finished segments, and the operand MSBs for overflow.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_q  <= 1'b0;
                c_q  <= 1'b0;
                am_q <= 1'b0;
                bm_q <= 1'b0;
                z_q  <= '0;
            end else if (en) begin
                v_q  <= v_d;
                c_q  <= sum[SEG];
                am_q <= am_d;
                bm_q <= bm_d;
                z_q  <= z_d;
            end
        end

        // Skew registers hold the operand segments that later stages still have to add.
        if (RW > 0) begin : g_skew
            logic [RW-1:0] a_q, b_q;
            logic [RW-1:0] a_d, b_d;

            if (k == 0) begin : g_op
                assign a_d = in_a[WIDTH-1:SEG];
                assign b_d = in_bp[WIDTH-1:SEG];
            end else begin : g_op
                assign a_d = g_stg[k-1].g_skew.a_q[RW+SEG-1:SEG];
                assign b_d = g_stg[k-1].g_skew.b_q[RW+SEG-1:SEG];
            end

            // Shift the unconsumed operand bits along with the beat.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end
    end

    // The outputs come only from final-stage state. Overflow means the operands
    // agreed in sign and the sum did not. After reset every register is zero,
    // so this also gives 0.
    assign out_valid = g_stg[NSTG-1].v_q;
    assign out_z     = g_stg[NSTG-1].z_q;
    assign out_cout  = g_stg[NSTG-1].c_q;
    assign out_ovf   = (g_stg[NSTG-1].am_q == g_stg[NSTG-1].bm_q) &&
                       (g_stg[NSTG-1].z_q[WIDTH-1] != g_stg[NSTG-1].am_q);

endmodule
